// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

    // Fetch controller states:
    //   FETCH   - no request outstanding
    //   WAIT    - one live request outstanding
    //   DISCARD - one stale request outstanding; its response is dropped
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } if_state_e;

    localparam logic [31:0] IF_START_PC = 32'h0040_0020;
    localparam int          WORD_BYTES  = 4;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {instruction, pc} pairs between fetch and decode.
// Flush empties the queue and takes priority over a same-cycle push or pop.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pop on empty is ignored; push on full is ignored as a safety net.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: PC register, single-outstanding request controller
// for a variable-latency instruction memory, and a decode-facing queue.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// memory accepts a request in any cycle imem_req is high, and responds with a
// one-cycle imem_valid strobe one or more cycles later.
module instr_fetch_queue
    import if_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] START_PC = IF_START_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    input  logic              redir_valid,
    input  logic              redir_jump,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [25:0]       redir_imm,
    output if_state_e         state_dbg
);

    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam int                QW       = 32 + ADDR_W;
    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(START_PC & 32'hFFFF_FFFC);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(WORD_BYTES);

    if_state_e         state;
    if_state_e         state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic [ADDR_W-1:0] redir_pc4;
    logic [ADDR_W-1:0] redir_tgt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_after;
    logic              q_full;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    logic              req_int;
    logic [QW-1:0]     q_rdata;

    assign redir_pc4 = redir_pc + STEP;
    // A redirect discards any same-cycle pop along with the flush.
    assign q_pop     = out_valid && out_ready && !redir_valid;
    // Occupancy after this cycle's push and pop; only meaningful when pushing.
    assign cnt_after = count + CNT_W'(1) - CNT_W'(q_pop);

    // Redirect target: PC-relative branch or region-relative jump.
    always_comb begin
        redir_tgt = redir_pc4;
        if (redir_jump) begin
            redir_tgt = (redir_pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({redir_imm, 2'b00});
        end else begin
            redir_tgt = redir_pc4 + {{(ADDR_W-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};
        end
    end

    // Next-state, request and push decode; redirect overrides everything.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_int       = 1'b0;
        q_push        = 1'b0;
        if (redir_valid) begin
            fetch_pc_next = redir_tgt;
            if (state == FETCH) state_next = FETCH;
            else                state_next = imem_valid ? FETCH : DISCARD;
        end else begin
            case (state)
                FETCH: begin
                    if (!q_full) begin
                        req_int       = 1'b1;
                        fetch_pc_next = fetch_pc + STEP;
                        state_next    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        q_push = 1'b1;
                        if (cnt_after < CNT_W'(DEPTH)) begin
                            req_int       = 1'b1;
                            fetch_pc_next = fetch_pc + STEP;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_valid) state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    // The strobe is held low while reset is asserted.
    assign imem_req  = req_int && rst_n;
    assign imem_addr = fetch_pc;
    assign state_dbg = state;

    // The response belongs to the request issued at fetch_pc - 4.
    fetch_queue #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redir_valid),
        .wdata ({imem_rdata, fetch_pc - STEP}),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (count)
    );

    assign out_valid = !q_empty;
    assign out_instr = q_rdata[QW-1:ADDR_W];
    assign out_pc    = q_rdata[ADDR_W-1:0];

endmodule
